// File: rtl/hazard_scoreboard.sv
// ID-stage hazard scoreboard: pending bits for long-latency ops, load-use detection and stall counting.
// Optional macro HAZARD_SCOREBOARD_WB_BYPASS_EN lets a same-cycle completion release raw/waw stalls.
module hazard_scoreboard #(
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned CNT_W   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_id_valid,
    input  logic [4:0]       i_id_rs1,
    input  logic             i_id_rs1_used,
    input  logic [4:0]       i_id_rs2,
    input  logic             i_id_rs2_used,
    input  logic [4:0]       i_id_rd,
    input  logic             i_id_regwrite,
    input  logic             i_id_long,
    input  logic             i_ex_memread,
    input  logic [4:0]       i_ex_rd,
    input  logic             i_flush,
    input  logic             i_wb_valid,
    input  logic [4:0]       i_wb_rd,
    output logic             o_stall,
    output logic [31:0]      o_pending,
    output logic [CNT_W-1:0] o_outstanding,
    output logic             o_error,
    output logic [15:0]      o_stall_cycles
);

    localparam int unsigned REG_N = 32;

    logic [REG_N-1:0] r_pending;
    logic [CNT_W-1:0] r_outstanding;
    logic             r_error;
    logic [15:0]      r_stall_cycles;

    logic [REG_N-1:0] w_pend_eff;
    logic [REG_N-1:0] w_clr_mask;
    logic [REG_N-1:0] w_set_mask;
    logic             w_clr_en;
    logic             w_set_en;
    logic             w_wb_orphan;
    logic             w_raw;
    logic             w_waw;
    logic             w_lu;
    logic             w_full;
    logic             w_stall;

    assign w_clr_en    = i_wb_valid & (i_wb_rd != 5'd0) & r_pending[i_wb_rd];
    assign w_wb_orphan = i_wb_valid & (i_wb_rd != 5'd0) & ~r_pending[i_wb_rd];
    assign w_clr_mask  = REG_N'(w_clr_en) << i_wb_rd;

`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
    // Register file writes before it reads, so a completing register is already safe to read.
    assign w_pend_eff = r_pending & ~w_clr_mask;
`else
    assign w_pend_eff = r_pending;
`endif

    assign w_raw  = (i_id_rs1_used & (i_id_rs1 != 5'd0) & w_pend_eff[i_id_rs1])
                  | (i_id_rs2_used & (i_id_rs2 != 5'd0) & w_pend_eff[i_id_rs2]);
    assign w_waw  = i_id_regwrite & (i_id_rd != 5'd0) & w_pend_eff[i_id_rd];
    assign w_lu   = i_ex_memread & (i_ex_rd != 5'd0)
                  & ((i_id_rs1_used & (i_id_rs1 == i_ex_rd))
                   | (i_id_rs2_used & (i_id_rs2 == i_ex_rd)));
    assign w_full = i_id_long & i_id_regwrite & (r_outstanding == CNT_W'(MAX_OUT));

    // A killed ID instruction never stalls and never issues.
    assign w_stall  = i_id_valid & ~i_flush & ~rst & (w_raw | w_waw | w_lu | w_full);
    assign w_set_en = i_id_valid & ~w_stall & ~i_flush & i_id_long & i_id_regwrite
                    & (i_id_rd != 5'd0);
    assign w_set_mask = REG_N'(w_set_en) << i_id_rd;

    // Set is applied after clear so a same-cycle set on the same register wins.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_pending      <= '0;
            r_outstanding  <= '0;
            r_error        <= 1'b0;
            r_stall_cycles <= '0;
        end else begin
            r_pending     <= ((r_pending & ~w_clr_mask) | w_set_mask) & ~REG_N'(1);
            r_outstanding <= r_outstanding + CNT_W'(w_set_en) - CNT_W'(w_clr_en);
            if (w_wb_orphan) begin
                r_error <= 1'b1;
            end
            if (w_stall && (r_stall_cycles != 16'hFFFF)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

    assign o_stall        = w_stall;
    assign o_pending      = r_pending;
    assign o_outstanding  = r_outstanding;
    assign o_error        = r_error;
    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench for hazard_scoreboard: directed scenarios plus random traffic against a reference model.
module tb_hazard_scoreboard;

    localparam int unsigned MAX_OUT = 4;
    localparam int unsigned CNT_W   = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             id_valid, id_rs1_used, id_rs2_used, id_regwrite, id_long;
    logic [4:0]       id_rs1, id_rs2, id_rd, ex_rd, wb_rd;
    logic             ex_memread, flush, wb_valid;
    logic             stall;
    logic [31:0]      pending;
    logic [CNT_W-1:0] outstanding;
    logic             error;
    logic [15:0]      stall_cycles;

    int n_pass  = 0;
    int n_total = 0;

    // Reference state, kept as plain arrays and integers.
    bit m_pend [32];
    int m_out;
    bit m_err;
    int m_sc;
    bit m_issued;

    hazard_scoreboard #(.MAX_OUT(MAX_OUT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .i_id_valid(id_valid), .i_id_rs1(id_rs1), .i_id_rs1_used(id_rs1_used),
        .i_id_rs2(id_rs2), .i_id_rs2_used(id_rs2_used), .i_id_rd(id_rd),
        .i_id_regwrite(id_regwrite), .i_id_long(id_long),
        .i_ex_memread(ex_memread), .i_ex_rd(ex_rd), .i_flush(flush),
        .i_wb_valid(wb_valid), .i_wb_rd(wb_rd),
        .o_stall(stall), .o_pending(pending), .o_outstanding(outstanding),
        .o_error(error), .o_stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic idle();
        rst = 0; id_valid = 0; id_rs1 = 0; id_rs1_used = 0; id_rs2 = 0; id_rs2_used = 0;
        id_rd = 0; id_regwrite = 0; id_long = 0; ex_memread = 0; ex_rd = 0;
        flush = 0; wb_valid = 0; wb_rd = 0;
    endtask

    task automatic instr(input logic [4:0] rs1, input bit u1, input logic [4:0] rs2,
                         input bit u2, input logic [4:0] rd, input bit wr, input bit lng);
        id_valid = 1; id_rs1 = rs1; id_rs1_used = u1; id_rs2 = rs2; id_rs2_used = u2;
        id_rd = rd; id_regwrite = wr; id_long = lng;
    endtask

    function automatic bit busy(input logic [4:0] r, input bit bypass_clear);
        if (r == 0) return 0;
        return m_pend[r] && !bypass_clear;
    endfunction

    function automatic bit model_stall();
        bit completing [32];
        bit raw, waw, lu, full;
        for (int i = 0; i < 32; i++) completing[i] = 0;
`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
        if (wb_valid && wb_rd != 0 && m_pend[wb_rd]) completing[wb_rd] = 1;
`endif
        if (rst || !id_valid || flush) return 0;
        raw  = (id_rs1_used && busy(id_rs1, completing[id_rs1])) ||
               (id_rs2_used && busy(id_rs2, completing[id_rs2]));
        waw  = id_regwrite && busy(id_rd, completing[id_rd]);
        lu   = ex_memread && ex_rd != 0 &&
               ((id_rs1_used && id_rs1 == ex_rd) || (id_rs2_used && id_rs2 == ex_rd));
        full = id_long && id_regwrite && m_out == int'(MAX_OUT);
        return raw || waw || lu || full;
    endfunction

    function automatic logic [31:0] model_pend_vec();
        logic [31:0] v;
        for (int i = 0; i < 32; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // One clock: check the combinational stall, advance the model, check registered outputs.
    task automatic step(input string tag);
        bit es, issue, clr;
        #1;
        es = model_stall();
        chk({tag, ".stall"}, 32'(stall), 32'(es));
        issue = id_valid && !es && !flush && id_long && id_regwrite && id_rd != 0 && !rst;
        clr   = wb_valid && wb_rd != 0 && m_pend[wb_rd];
        m_issued = issue;
        if (rst) begin
            for (int i = 0; i < 32; i++) m_pend[i] = 0;
            m_out = 0; m_err = 0; m_sc = 0;
        end else begin
            if (wb_valid && wb_rd != 0 && !m_pend[wb_rd]) m_err = 1;
            if (clr) m_pend[wb_rd] = 0;
            if (issue) m_pend[id_rd] = 1;
            m_out = m_out + int'(issue) - int'(clr);
            if (es && m_sc < 65535) m_sc++;
        end
        @(posedge clk);
        #1;
        chk({tag, ".pending"}, pending, model_pend_vec());
        chk({tag, ".outstanding"}, 32'(outstanding), 32'(m_out));
        chk({tag, ".error"}, 32'(error), 32'(m_err));
        chk({tag, ".stall_cycles"}, 32'(stall_cycles), 32'(m_sc));
        @(negedge clk);
    endtask

    initial begin
        int sc_before;
        idle();
        for (int i = 0; i < 32; i++) m_pend[i] = 0;
        m_out = 0; m_err = 0; m_sc = 0;
        @(negedge clk);

        // Reset state
        rst = 1; instr(5'd3, 1, 5'd4, 1, 5'd3, 1, 1);
        step("reset");
        chk("reset.pending_zero", pending, 32'h0);
        chk("reset.outstanding_zero", 32'(outstanding), 32'h0);
        idle();

        // Nothing pending: reading x5 does not stall
        instr(5'd5, 1, 5'd0, 0, 5'd6, 1, 0);
        #1 chk("nopend.stall", 32'(stall), 32'h0);
        step("nopend");

        // Load-use on rs2 stalls exactly one cycle
        instr(5'd1, 1, 5'd7, 1, 5'd8, 1, 0); ex_memread = 1; ex_rd = 7;
        #1 chk("lu.stall_hi", 32'(stall), 32'h1);
        step("lu.c0");
        ex_memread = 0;
        #1 chk("lu.stall_lo", 32'(stall), 32'h0);
        step("lu.c1");
        instr(5'd1, 1, 5'd0, 1, 5'd8, 1, 0); ex_memread = 1; ex_rd = 7;
        step("lu.rs2zero");
        instr(5'd1, 1, 5'd7, 0, 5'd8, 1, 0);
        step("lu.rs2unused");
        idle();

        // Long op to x9, then a reader of x9 stalls until completion
        instr(5'd0, 0, 5'd0, 0, 5'd9, 1, 1);
        step("long9.issue");
        chk("long9.pending", 32'(pending[9]), 32'h1);
        sc_before = int'(stall_cycles);
        instr(5'd9, 1, 5'd2, 1, 5'd10, 1, 0);
        for (int c = 0; c < 3; c++) step("raw9.wait");
        wb_valid = 1; wb_rd = 9;
        #1;
`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
        chk("raw9.wb_cycle", 32'(stall), 32'h0);
`else
        chk("raw9.wb_cycle", 32'(stall), 32'h1);
`endif
        step("raw9.wb");
        wb_valid = 0;
        #1 chk("raw9.after", 32'(stall), 32'h0);
        step("raw9.go");
`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
        chk("raw9.stall_count", 32'(int'(stall_cycles) - sc_before), 32'd3);
`else
        chk("raw9.stall_count", 32'(int'(stall_cycles) - sc_before), 32'd4);
`endif
        idle();

        // Fill to MAX_OUT, then a fifth long op waits for a completion
        for (int r = 1; r <= 4; r++) begin
            instr(5'd0, 0, 5'd0, 0, 5'(r), 1, 1);
            step("fill.issue");
        end
        chk("fill.outstanding", 32'(outstanding), 32'd4);
        instr(5'd0, 0, 5'd0, 0, 5'd10, 1, 1);
        #1 chk("full.stall", 32'(stall), 32'h1);
        step("full.c0");
        wb_valid = 1; wb_rd = 2;
        m_issued = 0;
        for (int c = 0; c < 4 && !m_issued; c++) begin
            step("full.wait");
            wb_valid = 0;
        end
        chk("full.issued", 32'(m_issued), 32'h1);
        chk("full.outstanding", 32'(outstanding), 32'd4);
        chk("full.pend2", 32'(pending[2]), 32'h0);
        idle();

        // Flush overrides a RAW and suppresses the issue of a long op to x6
        instr(5'd1, 1, 5'd3, 1, 5'd6, 1, 1); flush = 1;
        #1 chk("flush.stall", 32'(stall), 32'h0);
        step("flush");
        chk("flush.pend6", 32'(pending[6]), 32'h0);
        idle();
        wb_valid = 1; wb_rd = 6;
        step("orphan.wb");
        chk("orphan.error", 32'(error), 32'h1);
        idle();
        for (int c = 0; c < 3; c++) step("orphan.sticky");

        // Drain remaining pending registers
        for (int r = 1; r < 32; r++) begin
            if (m_pend[r]) begin
                wb_valid = 1; wb_rd = 5'(r);
                step("drain");
            end
        end
        idle();

        // Random traffic over a narrow register window to provoke collisions
        for (int c = 0; c < 400; c++) begin
            rst         = ($urandom_range(0, 99) == 0);
            id_valid    = ($urandom_range(0, 3) != 0);
            id_rs1      = 5'($urandom_range(0, 7));
            id_rs1_used = 1'($urandom);
            id_rs2      = 5'($urandom_range(0, 7));
            id_rs2_used = 1'($urandom);
            id_rd       = 5'($urandom_range(0, 7));
            id_regwrite = ($urandom_range(0, 3) != 0);
            id_long     = ($urandom_range(0, 2) == 0);
            ex_memread  = ($urandom_range(0, 3) == 0);
            ex_rd       = 5'($urandom_range(0, 7));
            flush       = ($urandom_range(0, 7) == 0);
            wb_valid    = ($urandom_range(0, 2) == 0);
            wb_rd       = 5'($urandom_range(0, 7));
            step("rand");
        end
        idle();

        // Reset with three ops outstanding clears everything
        rst = 1;
        step("rst2.pre");
        rst = 0;
        for (int r = 11; r <= 13; r++) begin
            instr(5'd0, 0, 5'd0, 0, 5'(r), 1, 1);
            step("rst2.issue");
        end
        idle();
        wb_valid = 1; wb_rd = 20;
        instr(5'd11, 1, 5'd0, 0, 5'd0, 0, 0);
        step("rst2.dirty");
        chk("rst2.outstanding3", 32'(outstanding), 32'd3);
        idle();
        rst = 1;
        step("rst2.reset");
        chk("rst2.pending", pending, 32'h0);
        chk("rst2.outstanding", 32'(outstanding), 32'h0);
        chk("rst2.error", 32'(error), 32'h0);
        chk("rst2.stall_cycles", 32'(stall_cycles), 32'h0);
        idle();
        wb_valid = 1; wb_rd = 12;
        step("rst2.stale_wb");
        chk("rst2.stale_error", 32'(error), 32'h1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
- Stall-side counterpart of the pipeline's forwarding logic, sitting in the ID stage.
- Forwarding resolves hazards by bypassing results; this block resolves the hazards forwarding cannot cover, and stalls ID in those cases.
- It tracks destination registers of in-flight long-latency ops (variable-latency loads, multi-cycle mul/div) in a pending-bit scoreboard and detects load-use hazards against the EX stage.
- It also enforces an outstanding-op limit and keeps a saturating stall-cycle performance counter.

Parameters:
- MAX_OUT, 4, maximum simultaneously outstanding long-latency ops (1..15).
- CNT_W, 4, width of the outstanding counter; must satisfy 2^CNT_W > MAX_OUT.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- id_valid  in  1  valid instruction in ID.
- id_rs1  in  5  source register 1.
- id_rs1_used  in  1  rs1 is read by the instruction.
- id_rs2  in  5  source register 2.
- id_rs2_used  in  1  rs2 is read by the instruction.
- id_rd  in  5  destination register.
- id_regwrite  in  1  instruction writes rd.
- id_long  in  1  instruction is long-latency (scoreboarded).
- ex_memread  in  1  instruction in EX is a load.
- ex_rd  in  5  destination register of the instruction in EX.
- flush  in  1  ID instruction is killed this cycle (taken branch/jump).
- wb_valid  in  1  a long-latency op completes this cycle.
- wb_rd  in  5  destination register of the completing op.
- stall  out  1  freeze PC and IF/ID; insert bubble into ID/EX.
- pending  out  32  scoreboard bits; bit 0 is always 0.
- outstanding  out  CNT_W  number of pending long ops.
- error  out  1  sticky: completion received for a non-pending register.
- stall_cycles  out  16  saturating count of cycles with stall=1.

Behaviour:
- Reset values (synchronous, while rst=1): pending=0, outstanding=0, error=0, stall_cycles=0. stall is combinational and is 0 while rst=1. Reset mid-operation discards all pending state; any later wb_valid for a pre-reset op sets error.
- Hazard terms, all qualified by id_valid:
  - raw = (id_rs1_used & id_rs1!=0 & pending[id_rs1]) | (id_rs2_used & id_rs2!=0 & pending[id_rs2]).
  - waw = id_regwrite & id_rd!=0 & pending[id_rd].
  - lu (load-use) = ex_memread & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd)).
  - full = id_long & id_regwrite & outstanding==MAX_OUT.
- stall = id_valid & !flush & !rst & (raw | waw | lu | full). flush overrides all other terms.
- Issue: set_en = id_valid & !stall & !flush & id_long & id_regwrite & id_rd!=0. On set_en, pending[id_rd] is set next cycle.
- Completion: clr_en = wb_valid & wb_rd!=0 & pending[wb_rd]. On clr_en, pending[wb_rd] is cleared next cycle.
  - wb_valid with wb_rd!=0 and pending[wb_rd]=0 sets error (sticky until rst); pending and outstanding are unchanged.
  - wb_valid with wb_rd=0 is ignored.
- Same register set and cleared in one cycle: the set wins, and pending stays 1.
- outstanding next value = outstanding + set_en - clr_en. Set and clear in the same cycle (any registers) leaves it unchanged. It never exceeds MAX_OUT, which full guarantees, and never underflows, which the clr_en qualification guarantees.
- Load-use stalls last exactly one cycle, because the load advances to MEM and forwarding covers it afterwards. Scoreboard stalls last until the clearing completion is visible as described under Optional Feature.
- stall_cycles increments by 1 each cycle stall=1 and saturates at 0xFFFF.

Optional Feature:
- Macro: HAZARD_SCOREBOARD_WB_BYPASS_EN.
- Defined: raw and waw treat a register as not pending when clr_en targets it in the same cycle. The stall drops in the completion cycle, assuming the register file writes first and reads second. An issue to the same rd in that cycle takes the set-wins rule.
- Undefined: hazard terms use registered pending only. The stall drops the cycle after completion, one extra bubble.

Test Plan:
- Reset, then an ID instruction reading x5 with nothing pending -> stall=0, pending=0, outstanding=0.
- ex_memread=1, ex_rd=7; ID instruction with rs2=7 used -> stall=1 for exactly 1 cycle. Same case with rs2=0 or rs2_used=0 -> stall=0.
- Issue long op, rd=9 -> pending[9]=1, outstanding=1. Next instruction reads x9 -> stalls until wb_valid with wb_rd=9. The stall drops in the same cycle if the bypass macro is defined, else one cycle later. stall_cycles equals the stalled-cycle count.
- Issue MAX_OUT=4 long ops to x1..x4, then a 5th long op -> stall=1 (full). wb_valid with wb_rd=2 on the following cycle -> the 5th op issues, outstanding stays 4, pending[2]=0.
- flush=1 with a long op to x6 and a RAW on a pending register -> stall=0 and pending[6] stays 0. wb_valid with wb_rd=6 afterwards -> error=1, and it stays 1 until rst.
- rst asserted with outstanding=3 -> next cycle pending=0, outstanding=0, error=0, stall_cycles=0.
